// File: rtl/task_fifo_mq.sv
// task_fifo_mq: shared-storage multi-queue FIFO with per-queue status, bypass and error pulses
module task_fifo_mq #(
    parameter int PTW = 16,
    parameter int MTW = 16,
    parameter int TREE_NUM = 4,
    parameter int BUF_SIZE = 8,
    parameter int AF_THRESH = BUF_SIZE - 2,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int BUF_WIDTH = $clog2(BUF_SIZE),
    localparam int DW = PTW + MTW + 2 * TREE_NUM_BITS + 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [TREE_NUM_BITS-1:0]            wr_tree,
    input  logic [DW-1:0]                       buf_in,
    input  logic                                rd_en,
    input  logic [TREE_NUM_BITS-1:0]            rd_tree,
    output logic [DW-1:0]                       buf_out,
    output logic                                o_out_valid,
    output logic [TREE_NUM-1:0]                 o_empty,
    output logic [TREE_NUM-1:0]                 o_full,
    output logic [TREE_NUM-1:0]                 o_almost_full,
    output logic [TREE_NUM*(BUF_WIDTH+1)-1:0]   o_fifo_counter,
    output logic                                o_overflow,
    output logic                                o_underflow
);
    logic [DW-1:0]        mem [TREE_NUM*BUF_SIZE];
    logic [BUF_WIDTH-1:0] wr_ptr_q [TREE_NUM], wr_ptr_d [TREE_NUM];
    logic [BUF_WIDTH-1:0] rd_ptr_q [TREE_NUM], rd_ptr_d [TREE_NUM];
    logic [BUF_WIDTH:0]   cnt_q [TREE_NUM], cnt_d [TREE_NUM];
    logic [DW-1:0]        buf_out_q, buf_out_d;
    logic                 valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                 wr_ok, rd_ok, bypass;
    logic [TREE_NUM-1:0]  wr_sel, rd_sel;

    always_comb begin
        wr_ok = wr_en && (cnt_q[wr_tree] != (BUF_WIDTH+1)'(BUF_SIZE) || (rd_en && rd_tree == wr_tree));
        rd_ok = rd_en && (cnt_q[rd_tree] != '0 || (wr_en && wr_tree == rd_tree));
        bypass = rd_ok && cnt_q[rd_tree] == '0;
        wr_sel = wr_ok ? TREE_NUM'(1) << wr_tree : '0;
        rd_sel = rd_ok ? TREE_NUM'(1) << rd_tree : '0;
        for (int i = 0; i < TREE_NUM; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + BUF_WIDTH'(wr_sel[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + BUF_WIDTH'(rd_sel[i]);
            cnt_d[i] = cnt_q[i] + (BUF_WIDTH+1)'(wr_sel[i]) - (BUF_WIDTH+1)'(rd_sel[i]);
        end
        buf_out_d = !rd_ok ? '0 : bypass ? buf_in : mem[{rd_tree, rd_ptr_q[rd_tree]}];
        valid_d = rd_ok;
        ovf_d = wr_en && !wr_ok;
        unf_d = rd_en && !rd_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q <= '{default: '0};
            buf_out_q <= '0;
            valid_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            buf_out_q <= buf_out_d;
            valid_q <= valid_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst)
            mem[{wr_tree, wr_ptr_q[wr_tree]}] <= buf_in;
    end

    for (genvar t = 0; t < TREE_NUM; t++) begin : g_stat
        assign o_empty[t] = cnt_q[t] == '0;
        assign o_full[t] = cnt_q[t] == (BUF_WIDTH+1)'(BUF_SIZE);
        assign o_almost_full[t] = cnt_q[t] >= (BUF_WIDTH+1)'(AF_THRESH);
        assign o_fifo_counter[t*(BUF_WIDTH+1) +: BUF_WIDTH+1] = cnt_q[t];
    end

    assign buf_out = buf_out_q;
    assign o_out_valid = valid_q;
    assign o_overflow = ovf_q;
    assign o_underflow = unf_q;
endmodule

// File: tb/tb_task_fifo_mq.sv
// tb_task_fifo_mq: directed plus random stimulus against a per-queue reference model
module tb_task_fifo_mq;
    localparam int DW = 38;
    localparam int TN = 4;
    localparam int BS = 8;
    localparam int AF = 6;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst, wr_en, rd_en;
    logic [1:0] wr_tree, rd_tree;
    logic [DW-1:0] buf_in, buf_out;
    logic o_out_valid, o_overflow, o_underflow;
    logic [TN-1:0] o_empty, o_full, o_almost_full;
    logic [TN*CW-1:0] o_fifo_counter;

    logic [DW-1:0] mq [TN][$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task_fifo_mq dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_tree(wr_tree), .buf_in(buf_in),
        .rd_en(rd_en), .rd_tree(rd_tree), .buf_out(buf_out), .o_out_valid(o_out_valid),
        .o_empty(o_empty), .o_full(o_full), .o_almost_full(o_almost_full),
        .o_fifo_counter(o_fifo_counter), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [1:0] wt, input logic [DW-1:0] din,
                        input logic re, input logic [1:0] rt);
        logic wacc, racc;
        logic [DW-1:0] eo;
        logic [TN-1:0] ee, ef, ea;
        logic [TN*CW-1:0] ec;
        rst = r;
        wr_en = we;
        wr_tree = wt;
        buf_in = din;
        rd_en = re;
        rd_tree = rt;
        eo = '0;
        wacc = !r && we && (mq[wt].size() < BS || (re && rt == wt));
        racc = !r && re && (mq[rt].size() > 0 || (we && wt == rt));
        if (r) begin
            for (int t = 0; t < TN; t++) mq[t].delete();
        end else if (racc && mq[rt].size() == 0) begin
            eo = din;
        end else begin
            if (racc) eo = mq[rt].pop_front();
            if (wacc) mq[wt].push_back(din);
        end
        @(posedge clk);
        #1;
        for (int t = 0; t < TN; t++) begin
            ee[t] = mq[t].size() == 0;
            ef[t] = mq[t].size() == BS;
            ea[t] = mq[t].size() >= AF;
            ec[t*CW +: CW] = CW'(mq[t].size());
        end
        chk("out_valid", 64'(o_out_valid), 64'(racc));
        chk("buf_out", 64'(buf_out), 64'(eo));
        chk("overflow", 64'(o_overflow), 64'(!r && we && !wacc));
        chk("underflow", 64'(o_underflow), 64'(!r && re && !racc));
        chk("fifo_counter", 64'(o_fifo_counter), 64'(ec));
        chk("empty", 64'(o_empty), 64'(ee));
        chk("full", 64'(o_full), 64'(ef));
        chk("almost_full", 64'(o_almost_full), 64'(ea));
    endtask

    initial begin
        logic [DW-1:0] d;
        step(1, 0, 0, '0, 0, 0);
        step(0, 1, 2, 38'h11, 0, 0);
        step(0, 1, 2, 38'h22, 0, 0);
        step(0, 1, 2, 38'h33, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 2);
        step(0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 1, DW'(38'h100 + i), 0, 0);
        step(0, 1, 1, 38'h1FF, 1, 1);
        step(0, 0, 0, '0, 1, 0);
        step(0, 1, 0, 38'hAB, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(38'h200 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 3, DW'(38'h300 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            d = DW'({$urandom(), $urandom()});
            if (i % 2 == 1) step(0, 1, 3, d, 1, 0);
            else step(0, 1, 0, d, 1, 3);
        end
        for (int i = 0; i < 5; i++) step(0, 1, 2, DW'(38'h500 + i), 0, 0);
        step(0, 0, 0, '0, 1, 2);
        step(1, 1, 2, 38'h5FF, 1, 2);
        step(0, 0, 0, '0, 1, 2);
        for (int i = 0; i < 400; i++) begin
            d = DW'({$urandom(), $urandom()});
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) ? 2'd1 : 2'($urandom_range(0, 3)), d,
                 $urandom_range(0, 9) < 5,
                 $urandom_range(0, 1) ? 2'd1 : 2'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
